// File: rtl/fifo_port_arbiter.sv
// Purpose: shares one list-control FIFO between clients A and B, one op per cycle, round-robin.
// Latency: grants are combinational; dequeue responses appear one cycle after the grant.
// Backpressure: a request waits (no grant) while its op is not serviceable or a flush is running.
module fifo_port_arbiter #(
    parameter int DW    = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_a_req,
    input  logic             i_a_op,
    input  logic [DW-1:0]    i_a_wdata,
    output logic             o_a_gnt,
    input  logic             i_b_req,
    input  logic             i_b_op,
    input  logic [DW-1:0]    i_b_wdata,
    output logic             o_b_gnt,
    output logic             o_rsp_valid,
    output logic             o_rsp_id,
    output logic [DW-1:0]    o_rsp_data,
    input  logic             i_flush_req,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_occ,
    output logic             o_fifo_enq,
    output logic             o_fifo_deq,
    output logic [DW-1:0]    o_fifo_in,
    input  logic [DW-1:0]    i_fifo_out,
    input  logic             i_fifo_full,
    input  logic             i_fifo_empty
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(8);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_gnt;     // 0 = A granted last, 1 = B granted last
    logic [CNT_W-1:0] r_occ;
    logic             r_rsp_valid;
    logic             r_rsp_id;

    logic             w_elig_a;
    logic             w_elig_b;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_enq;
    logic             w_deq;
    logic             w_rsp_set;
    logic [DW-1:0]    w_fifo_in;

    // A client is eligible only when the FIFO can actually service its op this cycle.
    assign w_elig_a = i_a_req & (i_a_op ? ~i_fifo_empty : ~i_fifo_full);
    assign w_elig_b = i_b_req & (i_b_op ? ~i_fifo_empty : ~i_fifo_full);

    // Next state, arbitration and FIFO strobes; everything is held off while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        w_enq       = 1'b0;
        w_deq       = 1'b0;
        w_rsp_set   = 1'b0;
        w_fifo_in   = '0;
        if (!rst) begin
            if (r_state == ST_RUN) begin
                if (i_flush_req) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    // On a tie the client that did not win last time goes first.
                    if (w_elig_a && (!w_elig_b || r_last_gnt)) begin
                        w_gnt_a = 1'b1;
                    end else if (w_elig_b) begin
                        w_gnt_b = 1'b1;
                    end
                    if (w_gnt_a) begin
                        w_enq     = ~i_a_op;
                        w_deq     = i_a_op;
                        w_fifo_in = i_a_wdata;
                    end else if (w_gnt_b) begin
                        w_enq     = ~i_b_op;
                        w_deq     = i_b_op;
                        w_fifo_in = i_b_wdata;
                    end
                    w_rsp_set = w_deq;
                end
            end else begin
                // Drain without responses; leave once the FIFO reports empty.
                w_deq = ~i_fifo_empty;
                if (i_fifo_empty) begin
                    w_state_nxt = ST_RUN;
                end
            end
        end
    end

    // State register, round-robin pointer and response pipeline stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_last_gnt  <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_rsp_set;
            r_rsp_id    <= w_gnt_b;
            if (w_gnt_a) begin
                r_last_gnt <= 1'b0;
            end else if (w_gnt_b) begin
                r_last_gnt <= 1'b1;
            end
        end
    end

    // Occupancy bookkeeping, saturating at empty and full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
        end else if (w_enq && (r_occ != OCC_MAX)) begin
            r_occ <= r_occ + 1'b1;
        end else if (w_deq && (r_occ != '0)) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    assign o_a_gnt     = w_gnt_a;
    assign o_b_gnt     = w_gnt_b;
    assign o_fifo_enq  = w_enq;
    assign o_fifo_deq  = w_deq;
    assign o_fifo_in   = w_fifo_in;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = i_fifo_out;
    assign o_busy      = (r_state == ST_FLUSH);
    assign o_occ       = r_occ;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter with a behavioural 8-entry FIFO attached.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units after it.
// The FIFO model presents its head on fifo_out one cycle after each dequeue.
module tb_fifo_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_op, b_req, b_op, flush_req;
    logic [3:0] a_wdata, b_wdata;
    logic       a_gnt, b_gnt, rsp_valid, rsp_id, busy;
    logic [3:0] rsp_data, occ;
    logic       fifo_enq, fifo_deq, fifo_full, fifo_empty;
    logic [3:0] fifo_in, fifo_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_port_arbiter #(.DW(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_a_req      (a_req),
        .i_a_op       (a_op),
        .i_a_wdata    (a_wdata),
        .o_a_gnt      (a_gnt),
        .i_b_req      (b_req),
        .i_b_op       (b_op),
        .i_b_wdata    (b_wdata),
        .o_b_gnt      (b_gnt),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_rsp_data   (rsp_data),
        .i_flush_req  (flush_req),
        .o_busy       (busy),
        .o_occ        (occ),
        .o_fifo_enq   (fifo_enq),
        .o_fifo_deq   (fifo_deq),
        .o_fifo_in    (fifo_in),
        .i_fifo_out   (fifo_out),
        .i_fifo_full  (fifo_full),
        .i_fifo_empty (fifo_empty)
    );

    // Behavioural FIFO: registered output, full/empty from its own count.
    logic [3:0] m_q[$];
    logic [3:0] m_cnt;
    logic [3:0] m_out;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_cnt <= 4'd0;
            m_out <= 4'd0;
        end else begin
            if (fifo_deq && m_q.size() != 0) m_out <= m_q.pop_front();
            if (fifo_enq && m_q.size() < 8) m_q.push_back(fifo_in);
            m_cnt <= 4'(m_q.size());
        end
    end

    assign fifo_out   = m_out;
    assign fifo_full  = (m_cnt == 4'd8);
    assign fifo_empty = (m_cnt == 4'd0);

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_op = 1'b0; a_wdata = 4'd0;
        b_req = 1'b0; b_op = 1'b0; b_wdata = 4'd0;
        flush_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_a(input int n);
        a_req = 1'b1; a_op = 1'b0;
        for (int i = 0; i < n; i++) begin
            a_wdata = 4'(i + 2);
            #1;
            chk1("fill_a_gnt", a_gnt, 1'b1);
            tick();
        end
        a_req = 1'b0;
    endtask

    // Keeps the run bounded even if a step stalls.
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [3:0] exp1[3];

    initial begin
        exp1[0] = 4'd3; exp1[1] = 4'd5; exp1[2] = 4'd7;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk4("rst_occ", occ, 4'd0);
        chk1("rst_a_gnt", a_gnt, 1'b0);
        chk1("rst_b_gnt", b_gnt, 1'b0);
        chk1("rst_fifo_deq", fifo_deq, 1'b0);

        // 1: A enqueues 3,5,7 then dequeues them back
        rst = 1'b0;
        a_req = 1'b1; a_op = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_wdata = exp1[i];
            #1;
            chk1("t1_enq_a_gnt", a_gnt, 1'b1);
            chk1("t1_enq_b_gnt", b_gnt, 1'b0);
            chk1("t1_fifo_enq", fifo_enq, 1'b1);
            chk4("t1_fifo_in", fifo_in, exp1[i]);
            tick();
        end
        a_req = 1'b0;
        #1;
        chk4("t1_occ3", occ, 4'd3);
        a_req = 1'b1; a_op = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("t1_deq_a_gnt", a_gnt, 1'b1);
            chk1("t1_fifo_deq", fifo_deq, 1'b1);
            chk1("t1_deq_no_enq", fifo_enq, 1'b0);
            tick();
            chk1("t1_rsp_valid", rsp_valid, 1'b1);
            chk1("t1_rsp_id", rsp_id, 1'b0);
            chk4("t1_rsp_data", rsp_data, exp1[i]);
        end
        #1;
        chk1("t1_empty_wait_gnt", a_gnt, 1'b0);
        chk1("t1_empty_wait_deq", fifo_deq, 1'b0);
        a_req = 1'b0;
        tick();
        chk1("t1_rsp_done", rsp_valid, 1'b0);
        chk4("t1_occ0", occ, 4'd0);

        // 2: both enqueue every cycle from empty; grants alternate starting with A
        do_reset();
        a_req = 1'b1; a_op = 1'b0; b_req = 1'b1; b_op = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_wdata = 4'(i + 1);
            b_wdata = 4'(i + 1);
            #1;
            chk1("t2_a_gnt", a_gnt, (i % 2) == 0);
            chk1("t2_b_gnt", b_gnt, (i % 2) == 1);
            chk1("t2_fifo_enq", fifo_enq, 1'b1);
            chk4("t2_fifo_in", fifo_in, 4'(i + 1));
            tick();
        end
        #1;
        chk1("t2_full_a_gnt", a_gnt, 1'b0);
        chk1("t2_full_b_gnt", b_gnt, 1'b0);
        chk1("t2_full_enq", fifo_enq, 1'b0);
        chk4("t2_occ8", occ, 4'd8);

        // 4: full FIFO, A enqueues while B dequeues -> B first, then A
        a_wdata = 4'd9;
        b_op = 1'b1;
        #1;
        chk1("t4_a_gnt0", a_gnt, 1'b0);
        chk1("t4_b_gnt", b_gnt, 1'b1);
        chk1("t4_deq", fifo_deq, 1'b1);
        chk1("t4_no_enq", fifo_enq, 1'b0);
        tick();
        b_req = 1'b0;
        chk1("t4_rsp_valid", rsp_valid, 1'b1);
        chk1("t4_rsp_id", rsp_id, 1'b1);
        chk4("t4_rsp_data", rsp_data, 4'd1);
        #1;
        chk1("t4_a_gnt1", a_gnt, 1'b1);
        chk1("t4_enq", fifo_enq, 1'b1);
        chk4("t4_fifo_in", fifo_in, 4'd9);
        tick();
        a_req = 1'b0;
        chk4("t4_occ8", occ, 4'd8);
        chk1("t4_rsp_clear", rsp_valid, 1'b0);

        // 3: one entry, both dequeue -> only B (A won last), A then waits on empty
        do_reset();
        a_req = 1'b1; a_op = 1'b0; a_wdata = 4'hC;
        #1;
        chk1("t3_setup_gnt", a_gnt, 1'b1);
        tick();
        a_op = 1'b1;
        b_req = 1'b1; b_op = 1'b1;
        #1;
        chk1("t3_a_gnt0", a_gnt, 1'b0);
        chk1("t3_b_gnt", b_gnt, 1'b1);
        tick();
        b_req = 1'b0;
        chk1("t3_rsp_valid", rsp_valid, 1'b1);
        chk1("t3_rsp_id", rsp_id, 1'b1);
        chk4("t3_rsp_data", rsp_data, 4'hC);
        #1;
        chk1("t3_a_waits", a_gnt, 1'b0);
        tick();
        #1;
        chk1("t3_a_still_waits", a_gnt, 1'b0);
        chk1("t3_no_deq", fifo_deq, 1'b0);
        chk1("t3_no_rsp", rsp_valid, 1'b0);
        a_req = 1'b0;

        // 5: five entries then flush; no grant on the pulse cycle, five drain cycles, one empty cycle
        fill_a(5);
        #1;
        chk4("t5_occ5", occ, 4'd5);
        a_req = 1'b1; a_op = 1'b1;
        flush_req = 1'b1;
        #1;
        chk1("t5_pulse_no_gnt", a_gnt, 1'b0);
        chk1("t5_pulse_no_deq", fifo_deq, 1'b0);
        chk1("t5_pulse_busy", busy, 1'b0);
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk1("t5_busy", busy, 1'b1);
            chk1("t5_flush_deq", fifo_deq, 1'b1);
            chk1("t5_flush_no_gnt", a_gnt, 1'b0);
            chk1("t5_no_rsp", rsp_valid, 1'b0);
            tick();
        end
        #1;
        chk1("t5_empty_busy", busy, 1'b1);
        chk1("t5_empty_no_deq", fifo_deq, 1'b0);
        chk1("t5_empty_no_rsp", rsp_valid, 1'b0);
        tick();
        a_req = 1'b0;
        chk1("t5_busy_drop", busy, 1'b0);
        chk4("t5_occ0", occ, 4'd0);
        chk1("t5_rsp_after", rsp_valid, 1'b0);

        // 6: reset during flush with three entries left
        fill_a(5);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk1("t6_flush_deq", fifo_deq, 1'b1);
            tick();
        end
        chk4("t6_occ3", occ, 4'd3);
        rst = 1'b1;
        #1;
        chk1("t6_rst_no_deq", fifo_deq, 1'b0);
        tick();
        chk1("t6_busy", busy, 1'b0);
        chk1("t6_rsp_valid", rsp_valid, 1'b0);
        chk4("t6_occ", occ, 4'd0);
        rst = 1'b0;
        #1;
        chk1("t6_after_deq", fifo_deq, 1'b0);
        tick();
        chk1("t6_after_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
